// File: rtl/mips_debug_pkg.sv
// Shared constants and state encodings for the MIPS host debug controller.
package mips_debug_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h01;
  localparam logic [7:0] CMD_RUN  = 8'h02;
  localparam logic [7:0] CMD_STEP = 8'h03;
  localparam logic [7:0] CMD_DUMP = 8'h04;
  localparam logic [7:0] CMD_HALT = 8'h05;

  localparam int NUM_REGS = 32;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_LOAD_CNT   = 4'd1,
    ST_LOAD_BYTE  = 4'd2,
    ST_LOAD_WRITE = 4'd3,
    ST_RUN        = 4'd4,
    ST_STEP       = 4'd5,
    ST_DUMP_ADDR  = 4'd6,
    ST_DUMP_LATCH = 4'd7,
    ST_DUMP_SEND  = 4'd8
  } dbg_state_t;

  typedef enum logic [1:0] {
    SER_IDLE = 2'd0,
    SER_SEND = 2'd1,
    SER_WAIT = 2'd2
  } ser_state_t;

endpackage

// File: rtl/debug_word_serializer.sv
// Emits one data word as bytes, MSB first, over a start/busy transmit handshake.
//
// state    | meaning
// SER_IDLE | waiting for a word to load
// SER_SEND | waiting for transmitter free, then issue one start pulse
// SER_WAIT | one-cycle gap so the transmitter can raise busy
module debug_word_serializer
  import mips_debug_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic [NB_DATA-1:0] i_word,
  input  logic               i_tx_busy,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_done
);

  localparam int NUM_BYTES = NB_DATA / NB_BYTE;
  localparam int NB_CNT    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  ser_state_t          state;
  ser_state_t          state_nxt;
  logic [NB_DATA-1:0]  shift_reg;
  logic [NB_CNT-1:0]   byte_left;

  assign o_tx_data = shift_reg[NB_DATA-1 -: NB_BYTE];

  // State register, word shifter and remaining-byte down-counter
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= SER_IDLE;
      shift_reg <= '0;
      byte_left <= '0;
    end else begin
      state <= state_nxt;
      if (i_load && (state == SER_IDLE)) begin
        shift_reg <= i_word;
        byte_left <= NB_CNT'(NUM_BYTES - 1);
      end else if (o_tx_start) begin
        shift_reg <= {shift_reg[NB_DATA-NB_BYTE-1:0], {NB_BYTE{1'b0}}};
        if (byte_left != '0) byte_left <= byte_left - 1'b1;
      end
    end
  end

  // Next state and handshake outputs; the last start pulse doubles as done
  always_comb begin
    state_nxt  = state;
    o_tx_start = 1'b0;
    o_done     = 1'b0;
    case (state)
      SER_IDLE: if (i_load) state_nxt = SER_SEND;
      SER_SEND: begin
        if (!i_tx_busy) begin
          o_tx_start = 1'b1;
          if (byte_left == '0) begin
            o_done    = 1'b1;
            state_nxt = SER_IDLE;
          end else begin
            state_nxt = SER_WAIT;
          end
        end
      end
      SER_WAIT: state_nxt = SER_SEND;
      default:  state_nxt = SER_IDLE;
    endcase
  end

endmodule

// File: rtl/mips_debug_unit.sv
// Host-side debug controller: program load, run/step/halt gating, register dump.
//
// state         | meaning
// ST_IDLE       | waiting for a command byte
// ST_LOAD_CNT   | waiting for instruction count N
// ST_LOAD_BYTE  | collecting 4 instruction bytes, MSB first
// ST_LOAD_WRITE | one-cycle instruction memory write
// ST_RUN        | pipeline enabled until HALT byte
// ST_STEP       | pipeline enabled for a single cycle
// ST_DUMP_ADDR  | present register index to the register file
// ST_DUMP_LATCH | register data valid, hand word to serializer
// ST_DUMP_SEND  | serializer streaming the 4 bytes of the word
module mips_debug_unit
  import mips_debug_pkg::*;
#(
  parameter int NB_ADDR = 32,
  parameter int NB_INST = 32,
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  input  logic               i_tx_busy,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_write,
  output logic [NB_INST-1:0] o_instruction,
  output logic [NB_ADDR-1:0] o_address,
  output logic               o_enable,
  output logic [NB_REG-1:0]  o_address_read_debug,
  input  logic [NB_DATA-1:0] i_data_read_debug,
  output logic               o_busy
);

  dbg_state_t         state;
  dbg_state_t         state_nxt;
  logic [NB_INST-1:0] shift_reg;
  logic [1:0]         byte_left;
  logic [7:0]         word_idx;
  logic [7:0]         words_left;
  logic [NB_REG-1:0]  reg_idx;
  logic               ser_load;
  logic               ser_done;

  // Write strobe and enable decode straight from state so reset clears them at once
  assign o_write              = (state == ST_LOAD_WRITE);
  assign o_enable             = (state == ST_RUN) || (state == ST_STEP);
  assign o_busy               = (state != ST_IDLE);
  assign o_address_read_debug = reg_idx;
  assign ser_load             = (state == ST_DUMP_LATCH);

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Load datapath, word/byte counters and dump register index
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      shift_reg     <= '0;
      byte_left     <= '0;
      word_idx      <= '0;
      words_left    <= '0;
      reg_idx       <= '0;
      o_instruction <= '0;
      o_address     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_rx_valid && (i_rx_data == CMD_LOAD)) word_idx <= '0;
          if (i_rx_valid && (i_rx_data == CMD_DUMP)) reg_idx  <= '0;
        end
        ST_LOAD_CNT: begin
          if (i_rx_valid) begin
            words_left <= i_rx_data;
            byte_left  <= 2'd3;
          end
        end
        ST_LOAD_BYTE: begin
          if (i_rx_valid) begin
            shift_reg <= {shift_reg[NB_INST-NB_BYTE-1:0], i_rx_data};
            if (byte_left == 2'd0) begin
              o_instruction <= {shift_reg[NB_INST-NB_BYTE-1:0], i_rx_data};
              o_address     <= NB_ADDR'({word_idx, 2'b00});
            end else begin
              byte_left <= byte_left - 2'd1;
            end
          end
        end
        ST_LOAD_WRITE: begin
          word_idx   <= word_idx + 8'd1;
          words_left <= words_left - 8'd1;
          byte_left  <= 2'd3;
        end
        ST_DUMP_SEND: begin
          if (ser_done && (reg_idx != NB_REG'(NUM_REGS - 1))) reg_idx <= reg_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next-state decode; bytes arriving in states that do not expect them are dropped
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_LOAD: state_nxt = ST_LOAD_CNT;
            CMD_RUN:  state_nxt = ST_RUN;
            CMD_STEP: state_nxt = ST_STEP;
            CMD_DUMP: state_nxt = ST_DUMP_ADDR;
            default:  state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_LOAD_CNT: begin
        if (i_rx_valid) state_nxt = (i_rx_data == '0) ? ST_IDLE : ST_LOAD_BYTE;
      end
      ST_LOAD_BYTE: begin
        if (i_rx_valid && (byte_left == 2'd0)) state_nxt = ST_LOAD_WRITE;
      end
      ST_LOAD_WRITE: state_nxt = (words_left == 8'd1) ? ST_IDLE : ST_LOAD_BYTE;
      ST_RUN: begin
        if (i_rx_valid && (i_rx_data == CMD_HALT)) state_nxt = ST_IDLE;
      end
      ST_STEP:       state_nxt = ST_IDLE;
      ST_DUMP_ADDR:  state_nxt = ST_DUMP_LATCH;
      ST_DUMP_LATCH: state_nxt = ST_DUMP_SEND;
      ST_DUMP_SEND: begin
        if (ser_done) state_nxt = (reg_idx == NB_REG'(NUM_REGS - 1)) ? ST_IDLE : ST_DUMP_ADDR;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  debug_word_serializer #(
    .NB_DATA(NB_DATA),
    .NB_BYTE(NB_BYTE)
  ) u_serializer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (ser_load),
    .i_word     (i_data_read_debug),
    .i_tx_busy  (i_tx_busy),
    .o_tx_data  (o_tx_data),
    .o_tx_start (o_tx_start),
    .o_done     (ser_done)
  );

endmodule

// File: tb/tb_mips_debug_unit.sv
// Scoreboard bench: stimulus pushes expected writes, bytes and enable bursts;
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_mips_debug_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        wr;
  logic [31:0] inst;
  logic [31:0] addr;
  logic        en;
  logic [4:0]  dbg_addr;
  logic [31:0] rf_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
  } wr_t;

  wr_t        exp_wr[$];
  logic [7:0] exp_tx[$];
  int         exp_en[$];

  int          en_len = 0;
  int          busy_cnt = 0;
  wr_t         got_wr;
  logic [7:0]  got_b;
  int          got_len;

  always #5 clk = ~clk;

  mips_debug_unit dut (
    .i_clk                (clk),
    .i_reset              (rst),
    .i_rx_data            (rx_data),
    .i_rx_valid           (rx_valid),
    .i_tx_busy            (tx_busy),
    .o_tx_data            (tx_data),
    .o_tx_start           (tx_start),
    .o_write              (wr),
    .o_instruction        (inst),
    .o_address            (addr),
    .o_enable             (en),
    .o_address_read_debug (dbg_addr),
    .i_data_read_debug    (rf_data),
    .o_busy               (busy)
  );

  // Register file stub with one-cycle read latency
  always @(posedge clk) rf_data <= 32'h1100_0000 + 32'(dbg_addr);

  // Transmitter model: busy for 10 cycles after each start
  always @(posedge clk or posedge rst) begin
    if (rst) busy_cnt <= 0;
    else if (tx_start) busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every write, tx byte and enable burst against the queues
  always @(negedge clk) begin
    if (!rst) begin
      if (wr) begin
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL write: unexpected write inst %h addr %h", inst, addr);
        end else begin
          got_wr = exp_wr.pop_front();
          if (inst !== got_wr.inst || addr !== got_wr.addr) begin
            errors++;
            $display("FAIL write: got inst %h addr %h expected inst %h addr %h",
                     inst, addr, got_wr.inst, got_wr.addr);
          end
        end
      end
      if (tx_start) begin
        checks++;
        if (tx_busy || wr) begin
          errors++;
          $display("FAIL tx_start_legal: start with busy=%b write=%b", tx_busy, wr);
        end
        checks++;
        if (exp_tx.size() == 0) begin
          errors++;
          $display("FAIL tx_byte: unexpected byte %h", tx_data);
        end else begin
          got_b = exp_tx.pop_front();
          if (tx_data !== got_b) begin
            errors++;
            $display("FAIL tx_byte: got %h expected %h", tx_data, got_b);
          end
        end
      end
      if (en) begin
        en_len++;
      end else if (en_len > 0) begin
        checks++;
        if (exp_en.size() == 0) begin
          errors++;
          $display("FAIL enable_burst: unexpected burst of %0d cycles", en_len);
        end else begin
          got_len = exp_en.pop_front();
          if (en_len != got_len) begin
            errors++;
            $display("FAIL enable_burst: got %0d cycles expected %0d", en_len, got_len);
          end
        end
        en_len = 0;
      end
    end
  end

  // Called at a negedge: one valid cycle followed by one idle cycle
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input int limit, input string name);
    int n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic do_load(input logic [31:0] words[$]);
    send_byte(8'h01);
    send_byte(8'(words.size()));
    foreach (words[k]) begin
      wr_t e;
      e.addr = 32'(k) * 32'd4;
      e.inst = words[k];
      exp_wr.push_back(e);
      for (int b = 3; b >= 0; b--) send_byte(words[k][b*8 +: 8]);
    end
    wait_idle(20, "load_done_busy");
  endtask

  task automatic do_run(input int g1, input int g2, input logic [7:0] junk);
    exp_en.push_back(4 + g1 + g2);
    send_byte(8'h02);
    idle(g1);
    send_byte(junk);
    idle(g2);
    send_byte(8'h05);
    idle(2);
    chk("run_busy_after_halt", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] words[$];
    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy",     {31'd0, busy}, 32'd0);
    chk("reset_write",    {31'd0, wr}, 32'd0);
    chk("reset_enable",   {31'd0, en}, 32'd0);
    chk("reset_tx_start", {31'd0, tx_start}, 32'd0);
    chk("reset_tx_data",  {24'd0, tx_data}, 32'd0);
    chk("reset_inst",     inst, 32'd0);
    chk("reset_addr",     addr, 32'd0);
    chk("reset_dbg_addr", {27'd0, dbg_addr}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Unknown byte and HALT in IDLE do nothing
    send_byte(8'hFF);
    chk("unknown_busy", {31'd0, busy}, 32'd0);
    send_byte(8'h05);
    chk("halt_idle_busy", {31'd0, busy}, 32'd0);
    chk("halt_idle_enable", {31'd0, en}, 32'd0);

    // LOAD N=0 then STEP honoured
    send_byte(8'h01);
    send_byte(8'h00);
    chk("load0_busy", {31'd0, busy}, 32'd0);
    exp_en.push_back(1);
    send_byte(8'h03);
    idle(2);

    // Directed LOAD N=2
    words = '{32'h2008_0005, 32'hAC01_0004};
    do_load(words);
    chk("load2_inst_hold", inst, 32'hAC01_0004);
    chk("load2_addr_hold", addr, 32'd4);

    // Randomized LOADs; address restarts at 0 each time
    for (int t = 0; t < 3; t++) begin
      words.delete();
      for (int k = 0; k < int'($urandom_range(1, 5)); k++) words.push_back($urandom());
      do_load(words);
    end

    // Reset after 2 of 4 bytes: aborts, nothing written
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'hDE);
    send_byte(8'hAD);
    rst = 1'b1;
    #1;
    chk("midload_reset_write", {31'd0, wr}, 32'd0);
    chk("midload_reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("midload_reset_addr", addr, 32'd0);
    chk("midload_reset_inst", inst, 32'd0);
    @(negedge clk);

    // STEP and RUN/HALT with ignored bytes inside RUN
    exp_en.push_back(1);
    send_byte(8'h03);
    idle(2);
    do_run(0, 0, 8'h07);
    do_run(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), 8'h01);
    do_run(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), 8'h04);

    // DUMP: 32 registers, MSB first; commands during dump are ignored
    for (int r = 0; r < 32; r++) begin
      logic [31:0] d;
      d = 32'h1100_0000 + 32'(r);
      for (int b = 3; b >= 0; b--) exp_tx.push_back(d[b*8 +: 8]);
    end
    send_byte(8'h04);
    send_byte(8'h02);
    send_byte(8'h01);
    wait_idle(6000, "dump_done_busy");
    idle(15);

    // Post-dump command still works
    exp_en.push_back(1);
    send_byte(8'h03);
    idle(4);

    chk("left_writes", 32'(exp_wr.size()), 32'd0);
    chk("left_tx_bytes", 32'(exp_tx.size()), 32'd0);
    chk("left_enable_bursts", 32'(exp_en.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

endmodule

// File: doc/mips_debug_unit.md
Name: mips_debug_unit

Overview:
- Host-side controller for the MIPS core's debug ports.
- Receives command bytes from a UART receiver and loads programs into instruction memory through the write/instruction/address port.
- Gates pipeline execution (run/step/halt) through the enable line.
- Dumps the register file through the debug read port and returns it as bytes to a UART transmitter.

Parameters:
- NB_ADDR, 32, instruction memory address width (byte address)
- NB_INST, 32, instruction width
- NB_DATA, 32, register file data width
- NB_REG, 5, register index width
- NB_BYTE, 8, UART byte width

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_rx_data  in  NB_BYTE  received byte
- i_rx_valid  in  1  one-cycle pulse; i_rx_data is valid in this cycle
- i_tx_busy  in  1  transmitter busy
- o_tx_data  out  NB_BYTE  byte to send
- o_tx_start  out  1  one-cycle transmit request
- o_write  out  1  instruction memory write strobe
- o_instruction  out  NB_INST  instruction word to write
- o_address  out  NB_ADDR  instruction memory byte address
- o_enable  out  1  pipeline clock enable
- o_address_read_debug  out  NB_REG  register file debug read index
- i_data_read_debug  in  NB_DATA  register file debug read data
- o_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; all outputs 0, including o_tx_data, o_instruction, o_address and o_address_read_debug; byte and word counters cleared.
- Command bytes, accepted only in IDLE on i_rx_valid:
  - 0x01 LOAD
  - 0x02 RUN
  - 0x03 STEP
  - 0x04 DUMP
  - 0x05 HALT
  - Any other value is ignored and the state stays IDLE.
- LOAD:
  - IDLE -> LOAD_CNT. The next rx byte is N, the instruction count (1..255). N=0 returns to IDLE with no writes.
  - LOAD_BYTE collects 4 bytes per instruction, MSB first, into a shift register.
  - After the 4th byte -> LOAD_WRITE: o_write=1 for exactly one cycle, o_instruction=assembled word, o_address=4*k, where k starts at 0 on every LOAD.
  - The cycle after the write, k increments.
  - After N writes -> IDLE; otherwise -> LOAD_BYTE.
  - o_enable=0 throughout LOAD.
  - o_instruction and o_address hold their last values after the write.
- RUN:
  - IDLE -> RUN; o_enable=1 from the next cycle.
  - In RUN, only rx byte 0x05 is honoured: o_enable drops in the next cycle, then IDLE. All other bytes are dropped.
- STEP: o_enable=1 for exactly one cycle, then IDLE.
- HALT received in IDLE: no effect.
- DUMP, for r = 0..31:
  - DUMP_ADDR: o_address_read_debug=r.
  - DUMP_LATCH, next cycle: i_data_read_debug is captured. The register file read has 1-cycle latency.
  - DUMP_SEND sends 4 bytes MSB first. Each byte: wait for !i_tx_busy, then pulse o_tx_start=1 with o_tx_data valid in the same cycle.
  - DUMP_WAIT: wait one cycle, then wait for !i_tx_busy before the next byte.
  - After r=31 byte 3 -> IDLE.
  - Total 128 bytes. o_enable=0 during DUMP. rx bytes received during DUMP are ignored.
- Simultaneous events:
  - i_rx_valid in the same cycle as a state exit: the byte is consumed only by the current state.
  - o_write and o_tx_start are never both high.
- Reset mid-LOAD or mid-DUMP: everything aborts immediately. A partial word is never written; o_write is forced to 0 asynchronously.
- Counter wrap: k is 8 bits and cannot exceed N≤255; o_address max is 0x3F8.

Decomposition:
- Package mips_debug_pkg contains:
  - command byte constants CMD_LOAD=0x01, CMD_RUN=0x02, CMD_STEP=0x03, CMD_DUMP=0x04, CMD_HALT=0x05
  - state encoding localparams
  - NUM_REGS=32
- One natural sub-module: debug_word_serializer. It takes a 32-bit word and emits 4 bytes over the tx_start/tx_busy handshake, with a done pulse. The top FSM handles command decode, load and run control.

Test Plan:
- Reset mid-operation: assert i_reset after 2 of 4 LOAD bytes -> o_write never pulses; state=IDLE; o_address=0.
- LOAD N=2: bytes 01 02 20 08 00 05 AC 01 00 04 -> o_write pulses twice:
  - 0x20080005 @ addr 0
  - 0xAC010004 @ addr 4
  - o_busy low afterwards.
- STEP then RUN/HALT:
  - byte 03 -> o_enable high exactly 1 cycle.
  - bytes 02, then 07, then 05 -> o_enable high from the cycle after 02 until the cycle after 05; byte 07 is ignored.
- DUMP with stub regfile returning data=0x11000000+r:
  - Transmitter holds busy 10 cycles per byte.
  - Required: 128 o_tx_start pulses, sequence 11 00 00 00, 11 00 00 01, … 11 00 00 1F.
  - No o_tx_start while busy.
- Unknown byte 0xFF and HALT in IDLE -> no output change; o_busy stays 0.
- LOAD N=0: bytes 01 00 -> back to IDLE; no o_write; next command 03 is honoured.
